smpl_pacer: RTL and testbench
=============================

// Module: smpl_pacer
// PURPOSE
//  Stereo sample buffer and rate pacer between the EQ engine and the speaker driver.
//  Absorbs bursty sample pairs from the EQ engine in a small FIFO.
//  Presents one pair to the speaker driver every PERIOD clocks, with a one-clock out_vld pulse.
//  Primes to half-full before playing. Mutes and flags on underrun or overflow.
// PARAMETERS
//  DEPTH   8     FIFO depth in L/R sample pairs; power of 2, >=4
//  PERIOD  1024  clocks per output sample; >=4
// PORTS
//  clk        in   1    system clock
//  rst        in   1    asynchronous active-high reset
//  en         in   1    play enable; low = stop output (FIFO keeps contents)
//  in_vld     in   1    sample pair valid from EQ engine
//  in_rdy     out  1    FIFO can accept (= !full)
//  in_lft     in   16   signed left sample
//  in_rght    in   16   signed right sample
//  out_vld    out  1    one-clock pulse: new pair on lft_chnnl/rght_chnnl
//  lft_chnnl  out  16   signed left sample to speaker driver, held between pulses
//  rght_chnnl out  16   signed right sample to speaker driver, held between pulses
//  fill       out  $clog2(DEPTH+1)  pairs currently stored
//  undr       out  1    sticky underrun flag
//  ovr        out  1    sticky overflow flag
//  clr_err    in   1    synchronous clear of undr/ovr
// BEHAVIOUR
//  Reset (async, rst=1):
//   - out_vld=0, lft_chnnl=rght_chnnl=0, fill=0, undr=ovr=0.
//   - state=IDLE, rate cnt=0, rd/wr ptrs=0.
//   - in_rdy=1 (FIFO empty).
//  Push:
//   - Occurs when in_vld&&in_rdy at a clock edge; pair written at wr_ptr, wr_ptr+1 mod DEPTH.
//   - fill visible +1 the next cycle.
//   - in_vld while full: pair dropped, ovr<=1. in_rdy depends only on full, so a pop in
//     the same cycle does not admit the push.
//  Rate counter (cnt):
//   - Counts only in RUN; 0..PERIOD-1, wraps to 0.
//   - tick = (cnt==PERIOD-1).
//   - cnt is forced to 0 in IDLE and PRIME.
//  FSM:
//   - IDLE: en=1 -> PRIME.
//   - PRIME: en=0 -> IDLE; fill>=DEPTH/2 -> RUN, cnt=0.
//   - RUN: en=0 -> IDLE (no pulse). On tick:
//     - fill>0: pop pair at rd_ptr (rd_ptr+1 mod DEPTH). Next cycle: out_vld=1, outputs = popped pair.
//     - fill==0: next cycle out_vld=1, outputs = 0/0, undr<=1, state -> PRIME.
//   - Any state: en=0 forces IDLE next cycle; outputs hold last values, out_vld=0.
//  Latency and rates:
//   - First pulse after entering RUN is PERIOD clocks after the RUN entry edge.
//   - Pulses are exactly PERIOD clocks apart while RUN is sustained.
//  Simultaneous push and pop:
//   - fill unchanged; both pointers advance.
//   - When fill==0 at tick, a same-cycle push does not bypass: the push is stored and the
//     underrun path is taken.
//  Error flags:
//   - undr and ovr are sticky until clr_err=1.
//   - A set event in the same cycle as clr_err wins (flag stays 1).
//  Arithmetic:
//   - fill is 0..DEPTH; ptrs are $clog2(DEPTH) bits with natural wrap.
//   - Data passes unmodified: no scaling, no sign conversion (the speaker driver converts).
//  Reset mid-operation: all state cleared immediately; FIFO contents lost.
// TESTING (bench: DEPTH=4, PERIOD=8)
//  1. Reset, en=1, push 0x1234/0xEDCC then 0x0001/0xFFFF:
//     - RUN entered when fill=2.
//     - out_vld 8 clks later with 0x1234/0xEDCC; next pulse 8 clks after with 0x0001/0xFFFF.
//  2. Push 5 pairs back-to-back with en=0:
//     - fill=4, in_rdy=0 after 4th push.
//     - 5th pair dropped, ovr=1.
//     - clr_err -> ovr=0.
//  3. RUN with fill=0 at tick:
//     - out_vld with 0x0000/0x0000, undr=1, state PRIME.
//     - No pulses until fill>=2.
//  4. Push with in_vld at exactly the tick cycle while fill=1:
//     - Popped pair output; fill stays 1; pointers each +1.
//  5. Drop en mid-RUN with fill=3:
//     - No further out_vld; outputs hold; fill stays 3.
//     - en=1 -> immediate PRIME->RUN, next pulse PERIOD clks later.
//  6. Assert rst mid-RUN:
//     - Same cycle: out_vld=0, outputs 0, fill=0, flags 0, in_rdy=1.

Source files
------------

// File: rtl/smpl_pacer_if.sv
// smpl_pacer_if: EQ-side push, speaker-side paced output, status and error-clear signals.
interface smpl_pacer_if #(parameter int DEPTH = 8);
    logic                         en;
    logic                         in_vld;
    logic                         in_rdy;
    logic [15:0]                  in_lft;
    logic [15:0]                  in_rght;
    logic                         out_vld;
    logic [15:0]                  lft_chnnl;
    logic [15:0]                  rght_chnnl;
    logic [$clog2(DEPTH+1)-1:0]   fill;
    logic                         undr;
    logic                         ovr;
    logic                         clr_err;
    modport master (output en, in_vld, in_lft, in_rght, clr_err,
                    input  in_rdy, out_vld, lft_chnnl, rght_chnnl, fill, undr, ovr);
    modport slave  (input  en, in_vld, in_lft, in_rght, clr_err,
                    output in_rdy, out_vld, lft_chnnl, rght_chnnl, fill, undr, ovr);
endinterface

// File: rtl/smpl_pacer.sv
// smpl_pacer: stereo sample FIFO that primes to half-full, then emits one pair every PERIOD clocks.
module smpl_pacer #(
    parameter int DEPTH  = 8,
    parameter int PERIOD = 1024
) (
    input  logic        clk,
    input  logic        rst,
    smpl_pacer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(PERIOD);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wr, r_rd;
    logic [FW-1:0] r_fill;
    logic [15:0]   r_mem_l [DEPTH];
    logic [15:0]   r_mem_r [DEPTH];
    logic          r_out_vld, r_undr, r_ovr;
    logic [15:0]   r_lft, r_rght;
    logic          w_full, w_push, w_tick, w_pop, w_undr;
    logic [1:0]    w_nxt;

    assign w_full = r_fill == FW'(DEPTH);
    assign w_push = bus.in_vld && !w_full;
    assign w_tick = r_state == RUN && bus.en && r_cnt == CW'(PERIOD - 1);
    assign w_pop  = w_tick && r_fill != '0;
    assign w_undr = w_tick && r_fill == '0;
    // Underrun falls back to PRIME so playback resumes only after re-priming.
    assign w_nxt  = !bus.en            ? IDLE :
                    r_state == IDLE    ? PRIME :
                    r_state == PRIME   ? (r_fill >= FW'(DEPTH / 2) ? RUN : PRIME) :
                    w_undr             ? PRIME : r_state;

    assign bus.in_rdy     = !w_full;
    assign bus.out_vld    = r_out_vld;
    assign bus.lft_chnnl  = r_lft;
    assign bus.rght_chnnl = r_rght;
    assign bus.fill       = r_fill;
    assign bus.undr       = r_undr;
    assign bus.ovr        = r_ovr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_l[r_wr] <= bus.in_lft;
            r_mem_r[r_wr] <= bus.in_rght;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_fill    <= '0;
            r_out_vld <= 1'b0;
            r_lft     <= '0;
            r_rght    <= '0;
            r_undr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_cnt     <= (r_state == RUN && bus.en && !w_tick) ? r_cnt + 1'b1 : '0;
            r_wr      <= r_wr + AW'(w_push);
            r_rd      <= r_rd + AW'(w_pop);
            r_fill    <= r_fill + FW'(w_push) - FW'(w_pop);
            r_out_vld <= w_tick;
            if (w_tick) begin
                r_lft  <= w_pop ? r_mem_l[r_rd] : '0;
                r_rght <= w_pop ? r_mem_r[r_rd] : '0;
            end
            r_undr    <= w_undr || (r_undr && !bus.clr_err);
            r_ovr     <= (bus.in_vld && w_full) || (r_ovr && !bus.clr_err);
        end
    end
endmodule

// File: tb/tb_smpl_pacer.sv
// tb_smpl_pacer: directed scenarios plus random traffic checked every cycle against a queue model.
module tb_smpl_pacer;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    smpl_pacer_if #(.DEPTH(DEPTH)) bus ();
    smpl_pacer #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          n = 0, mode = 0, due = 0;
    logic [15:0] ql[$], qr[$];
    logic        m_vld = 1'b0, m_undr = 1'b0, m_ovr = 1'b0;
    logic [15:0] m_l = '0, m_r = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model works in absolute edge numbers: a pulse is due PERIOD edges after RUN entry or the last pulse.
    task automatic model_step();
        int sz = ql.size();
        bit full = sz == DEPTH;
        bit pulse;
        n++;
        pulse = mode == 2 && bus.en && n == due;
        m_vld = pulse;
        if (pulse) begin
            due = n + PERIOD;
            if (sz > 0) begin
                m_l = ql.pop_front();
                m_r = qr.pop_front();
            end else begin
                m_l = '0;
                m_r = '0;
            end
        end
        m_undr = (pulse && sz == 0) || (m_undr && !bus.clr_err);
        m_ovr  = (bus.in_vld && full) || (m_ovr && !bus.clr_err);
        if (bus.in_vld && !full) begin
            ql.push_back(bus.in_lft);
            qr.push_back(bus.in_rght);
        end
        if (!bus.en) mode = 0;
        else if (mode == 0) mode = 1;
        else if (mode == 1 && sz >= DEPTH / 2) begin
            mode = 2;
            due  = n + PERIOD;
        end else if (pulse && sz == 0) mode = 1;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mode = 0;
            ql.delete();
            qr.delete();
            m_vld = 1'b0; m_undr = 1'b0; m_ovr = 1'b0;
            m_l = '0; m_r = '0;
        end else model_step();
    end

    initial forever begin
        @(negedge clk);
        check("out_vld", bus.out_vld, m_vld);
        check("lft_chnnl", bus.lft_chnnl, m_l);
        check("rght_chnnl", bus.rght_chnnl, m_r);
        check("fill", bus.fill, ql.size());
        check("in_rdy", bus.in_rdy, ql.size() < DEPTH);
        check("undr", bus.undr, m_undr);
        check("ovr", bus.ovr, m_ovr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int lim, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (!bus.out_vld && c < lim);
        check("pulse_timeout", bus.out_vld, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.in_vld = 1'b0; bus.clr_err = 1'b0;
        bus.in_lft = '0; bus.in_rght = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        bus.in_vld = 1'b1; bus.in_lft = l; bus.in_rght = r;
        step();
        bus.in_vld = 1'b0;
    endtask

    initial begin
        int c, pulses;
        do_reset();
        check("rst_fill", bus.fill, 0);
        check("rst_rdy", bus.in_rdy, 1);
        check("rst_vld", bus.out_vld, 0);

        // first pulse timing and data, then an underrun
        bus.en = 1'b1;
        push(16'h1234, 16'hEDCC);
        push(16'h0001, 16'hFFFF);
        wait_pulse(40, c);
        check("s1_lat", c, 9);
        check("s1_l0", bus.lft_chnnl, 16'h1234);
        check("s1_r0", bus.rght_chnnl, 16'hEDCC);
        wait_pulse(40, c);
        check("s1_gap", c, PERIOD);
        check("s1_l1", bus.lft_chnnl, 16'h0001);
        check("s1_r1", bus.rght_chnnl, 16'hFFFF);
        wait_pulse(40, c);
        check("s3_gap", c, PERIOD);
        check("s3_l", bus.lft_chnnl, 16'h0000);
        check("s3_r", bus.rght_chnnl, 16'h0000);
        check("s3_undr", bus.undr, 1);
        pulses = 0;
        repeat (20) begin step(); pulses += int'(bus.out_vld); end
        check("s3_nopulse", pulses, 0);
        bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
        check("s3_clr", bus.undr, 0);

        // overflow with en low
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(16'(16'h100 + i), 16'(16'h200 + i));
            if (i == 3) begin
                check("s2_fill4", bus.fill, 4);
                check("s2_rdy0", bus.in_rdy, 0);
                check("s2_ovr0", bus.ovr, 0);
            end
        end
        check("s2_fill", bus.fill, 4);
        check("s2_ovr", bus.ovr, 1);
        bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
        check("s2_clr", bus.ovr, 0);

        // push exactly on the tick with fill=1
        do_reset();
        bus.en = 1'b1;
        push(16'hAAAA, 16'h5555);
        push(16'hBBBB, 16'h4444);
        wait_pulse(40, c);
        check("s4_fill1", bus.fill, 1);
        repeat (7) step();
        push(16'hCCCC, 16'h3333);
        check("s4_vld", bus.out_vld, 1);
        check("s4_l", bus.lft_chnnl, 16'hBBBB);
        check("s4_fill", bus.fill, 1);
        wait_pulse(40, c);
        check("s4_gap", c, PERIOD);
        check("s4_l2", bus.lft_chnnl, 16'hCCCC);
        check("s4_r2", bus.rght_chnnl, 16'h3333);

        // drop en mid-RUN, resume, then reset mid-RUN
        do_reset();
        for (int i = 0; i < 5; i++) push(16'(16'h7000 + i), 16'(16'h8000 + i));
        check("s5_ovr", bus.ovr, 1);
        bus.en = 1'b1;
        wait_pulse(40, c);
        check("s5_lat", c, 10);
        check("s5_l0", bus.lft_chnnl, 16'h7000);
        check("s5_fill", bus.fill, 3);
        repeat (3) step();
        bus.en = 1'b0;
        pulses = 0;
        repeat (20) begin step(); pulses += int'(bus.out_vld); end
        check("s5_nopulse", pulses, 0);
        check("s5_hold", bus.rght_chnnl, 16'h8000);
        check("s5_fill3", bus.fill, 3);
        bus.en = 1'b1;
        wait_pulse(40, c);
        check("s5_relat", c, 10);
        check("s5_l1", bus.lft_chnnl, 16'h7001);
        repeat (3) step();
        #1 rst = 1'b1;
        #1;
        check("s6_vld", bus.out_vld, 0);
        check("s6_l", bus.lft_chnnl, 0);
        check("s6_fill", bus.fill, 0);
        check("s6_ovr", bus.ovr, 0);
        check("s6_undr", bus.undr, 0);
        check("s6_rdy", bus.in_rdy, 1);
        step();
        do_reset();

        // random traffic with varying push density
        for (int b = 0; b < 8; b++) begin
            int prob = int'($urandom_range(5, 40));
            repeat (500) begin
                bus.en      = $urandom_range(0, 29) != 0;
                bus.in_vld  = int'($urandom_range(0, 99)) < prob;
                bus.in_lft  = 16'($urandom);
                bus.in_rght = 16'($urandom);
                bus.clr_err = $urandom_range(0, 49) == 0;
                rst         = $urandom_range(0, 999) == 0;
                step();
            end
        end
        rst = 1'b0;
        bus.in_vld = 1'b0;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
